bubbledrive8_supervisor: RTL and testbench
==========================================

Name: bubbledrive8_supervisor

Overview:
Parametrised power-state supervisor for BubbleDrive8. It replaces the fixed startup/blink logic at top level and sits between the board power pins, the DIP switches and the enable inputs of the emucore, tempsense and usb blocks. It generalises settle time, blink period and switch width. It adds input debouncing and live re-evaluation: loss of board power in emulator mode returns the block to reset instead of latching forever.

Parameters:
BLINK_CYCLES, 48000000, MCLK cycles per blink half-period (one "tick").
SETTLE_TICKS, 4, ticks spent in SETTLE before evaluation (range 1..255).
DEBOUNCE_CYCLES, 480000, consecutive identical samples required to accept a new {PWRSTAT,MRST} value (range ≥1).
SW_WIDTH, 10, width of the DIP switch bundle.

Ports:
MCLK  in  1  system clock, 48 MHz.
RST  in  1  synchronous, active-high reset.
PWRSTAT  in  1  async; 0 = motherboard power, 1 = USB power.
MRST  in  1  async board power status.
SWIN  in  SW_WIDTH  raw DIP switches, active-low.
nDELAYING_IN  in  1  active-low "delaying" flag from tempsense.
SETTINGS  out  SW_WIDTH  switches latched in RESET state, inverted (1 = switch on).
nEMUEN, nTEMPEN, nFIFOEN, nMPSSEEN  out  1 each  active-low block enables.
nLED_PWROK, nLED_STANDBY, nLED_DELAYING  out  1 each  active-low LEDs.
STATE  out  3  current state encoding, for debug.

Behaviour:
- Reset: reset is synchronous and active-high; the clock port is MCLK and the reset port is RST. On any MCLK edge with RST=1:
  - state=RESET, SETTINGS=0, all enables=1, all LEDs=1.
  - Blink counter, tick count and debounce counter are cleared; blink=1.
  - Stable pair is set to 2'b11.
  - RST mid-operation has identical effect.
- Input conditioning:
  - PWRSTAT and MRST each pass through a 2-flop synchroniser.
  - When the synchronised pair equals the stable pair, the debounce counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable is loaded with the synchronised pair and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Blinker: enabled only in SETTLE, MPSSE_STANDBY, ERR_BOARD and ERR_USB.
  - While enabled, the counter runs 0..BLINK_CYCLES-1. At BLINK_CYCLES-1 it emits a one-cycle tick, toggles blink and wraps to 0.
  - The tick count increments on each tick and saturates at SETTLE_TICKS.
  - While disabled: counter=0, blink=1, tick count=0.
- States (encoding) and transitions:
  - RESET(0): SETTINGS<=~SWIN; go to SETTLE next cycle.
  - SETTLE(1): when tick count==SETTLE_TICKS, go to EVAL.
  - EVAL(2): one cycle; stable {PWRSTAT,MRST}: 00→EMULATOR, 01→ERR_BOARD, 10→ERR_USB, 11→MPSSE_STANDBY.
  - EMULATOR(3): stay while stable==00; otherwise go to RESET.
  - MPSSE_STANDBY(4): stay while stable==11; otherwise go to RESET.
  - ERR_BOARD(5): stay while stable MRST==1; otherwise go to RESET.
  - ERR_USB(6): stay while stable==10; otherwise go to RESET.
  - Encoding 7 is illegal and goes to RESET.
- Outputs are registered from the current state, so they lag the state by 1 cycle:
  - nEMUEN, nTEMPEN, nFIFOEN: 0 only in EMULATOR.
  - nMPSSEEN: 0 only in MPSSE_STANDBY.
  - nLED_PWROK: 0 in EMULATOR and MPSSE_STANDBY; equals blink in SETTLE, ERR_BOARD and ERR_USB; 1 otherwise.
  - nLED_STANDBY: 0 when (MPSSE_STANDBY and blink==0) or nDELAYING_IN==0; else 1.
  - nLED_DELAYING: 0 only when in EMULATOR and nDELAYING_IN==0.
- SETTINGS changes only in RESET. SWIN changes at any other time are ignored.

Test Plan:
Use BLINK_CYCLES=4, SETTLE_TICKS=2, DEBOUNCE_CYCLES=3 for all scenarios.
1. Hold RST 2 cycles, release with SWIN=10'h3F0 and {PWRSTAT,MRST}=00 → SETTINGS=10'h00F; STATE goes 0,1; after 2 ticks (8 cycles) STATE=2 then 3; nEMUEN/nTEMPEN/nFIFOEN=0 one cycle later; nMPSSEEN=1.
2. Hold {PWRSTAT,MRST}=11 → MPSSE_STANDBY; nMPSSEEN=0; nLED_STANDBY toggles every 4 cycles; nLED_PWROK=0.
3. In EMULATOR, pulse MRST=1 for 2 cycles → state stays 3. Hold MRST=1 for ≥3 synchronised cycles → STATE=0, and all enables=1 the following cycle.
4. Bring up with MRST=1, PWRSTAT=0 → ERR_BOARD with nLED_PWROK blinking at 4-cycle half-period. Drop MRST to 0 → RESET→SETTLE→EVAL→EMULATOR.
5. In EMULATOR, drive nDELAYING_IN=0 → nLED_DELAYING=0 and nLED_STANDBY=0. Release → both return to 1.
6. Assert RST while in MPSSE_STANDBY with blink=0 → next edge: STATE=0, nMPSSEEN=1, all LEDs=1, SETTINGS=0.

Source files
------------

// File: rtl/bubbledrive8_supervisor.sv
// BubbleDrive8 power-state supervisor.
// Debounces the board power pins, sequences RESET -> SETTLE -> EVAL -> operating
// state, and drives the active-low block enables and status LEDs. Every operating
// state keeps checking the debounced pins and falls back to RESET when they change.
module bubbledrive8_supervisor #(
    parameter int unsigned BLINK_CYCLES    = 48000000,
    parameter int unsigned SETTLE_TICKS    = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 480000,
    parameter int unsigned SW_WIDTH        = 10
) (
    input  logic                MCLK,
    input  logic                RST,
    input  logic                PWRSTAT,
    input  logic                MRST,
    input  logic [SW_WIDTH-1:0] SWIN,
    input  logic                nDELAYING_IN,
    output logic [SW_WIDTH-1:0] SETTINGS,
    output logic                nEMUEN,
    output logic                nTEMPEN,
    output logic                nFIFOEN,
    output logic                nMPSSEEN,
    output logic                nLED_PWROK,
    output logic                nLED_STANDBY,
    output logic                nLED_DELAYING,
    output logic [2:0]          STATE
);

    localparam int BCW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_EVAL      = 3'd2,
        ST_EMULATOR  = 3'd3,
        ST_STANDBY   = 3'd4,
        ST_ERR_BOARD = 3'd5,
        ST_ERR_USB   = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync1_q, sync2_q;   // {PWRSTAT, MRST}
    logic [1:0]          stable_q;
    logic [DCW-1:0]      dbc_q;
    logic [BCW-1:0]      bcnt_q;
    logic                blink_q;
    logic [7:0]          tcnt_q;
    logic                blink_en, tick;
    logic [SW_WIDTH-1:0] settings_q;
    logic                nemu_q, nmpsse_q, npwrok_q, nstby_q, ndly_q;
    logic                nemu_d, nmpsse_d, npwrok_d, nstby_d, ndly_d;

    // Two-flop synchroniser for the async power pins; pure delay, so no reset needed.
    always_ff @(posedge MCLK) begin
        sync1_q <= {PWRSTAT, MRST};
        sync2_q <= sync1_q;
    end

    // Debounce: accept a new pin pair only after DEBOUNCE_CYCLES differing samples in a row.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            stable_q <= 2'b11;
            dbc_q    <= '0;
        end else if (sync2_q == stable_q) begin
            dbc_q <= '0;
        end else if (dbc_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
            stable_q <= sync2_q;
            dbc_q    <= '0;
        end else begin
            dbc_q <= dbc_q + DCW'(1);
        end
    end

    assign blink_en = state_q inside {ST_SETTLE, ST_STANDBY, ST_ERR_BOARD, ST_ERR_USB};
    assign tick     = blink_en && (bcnt_q == BCW'(BLINK_CYCLES - 1));

    // Blinker: free-running half-period counter with a saturating tick count, idle when disabled.
    always_ff @(posedge MCLK) begin
        if (RST || !blink_en) begin
            bcnt_q  <= '0;
            blink_q <= 1'b1;
            tcnt_q  <= '0;
        end else if (tick) begin
            bcnt_q  <= '0;
            blink_q <= ~blink_q;
            if (tcnt_q != 8'(SETTLE_TICKS))
                tcnt_q <= tcnt_q + 8'd1;
        end else begin
            bcnt_q <= bcnt_q + BCW'(1);
        end
    end

    // Next-state logic; every operating state re-checks the debounced pins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_SETTLE;
            ST_SETTLE: if (tcnt_q == 8'(SETTLE_TICKS)) state_d = ST_EVAL;
            ST_EVAL: begin
                case (stable_q)
                    2'b00:   state_d = ST_EMULATOR;
                    2'b01:   state_d = ST_ERR_BOARD;
                    2'b10:   state_d = ST_ERR_USB;
                    default: state_d = ST_STANDBY;
                endcase
            end
            ST_EMULATOR:  if (stable_q != 2'b00) state_d = ST_RESET;
            ST_STANDBY:   if (stable_q != 2'b11) state_d = ST_RESET;
            ST_ERR_BOARD: if (!stable_q[0])      state_d = ST_RESET;
            ST_ERR_USB:   if (stable_q != 2'b10) state_d = ST_RESET;
            default:      state_d = ST_RESET;
        endcase
    end

    // Output decode from the current state; registered below, so outputs trail STATE by a cycle.
    always_comb begin
        nemu_d   = (state_q != ST_EMULATOR);
        nmpsse_d = (state_q != ST_STANDBY);
        npwrok_d = 1'b1;
        if (state_q == ST_EMULATOR || state_q == ST_STANDBY)
            npwrok_d = 1'b0;
        else if (state_q inside {ST_SETTLE, ST_ERR_BOARD, ST_ERR_USB})
            npwrok_d = blink_q;
        nstby_d  = !((state_q == ST_STANDBY && !blink_q) || !nDELAYING_IN);
        ndly_d   = !(state_q == ST_EMULATOR && !nDELAYING_IN);
    end

    // State, switch latch and output registers.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            state_q    <= ST_RESET;
            settings_q <= '0;
            nemu_q     <= 1'b1;
            nmpsse_q   <= 1'b1;
            npwrok_q   <= 1'b1;
            nstby_q    <= 1'b1;
            ndly_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            if (state_q == ST_RESET)
                settings_q <= ~SWIN;
            nemu_q   <= nemu_d;
            nmpsse_q <= nmpsse_d;
            npwrok_q <= npwrok_d;
            nstby_q  <= nstby_d;
            ndly_q   <= ndly_d;
        end
    end

    assign SETTINGS      = settings_q;
    assign nEMUEN        = nemu_q;
    assign nTEMPEN       = nemu_q;
    assign nFIFOEN       = nemu_q;
    assign nMPSSEEN      = nmpsse_q;
    assign nLED_PWROK    = npwrok_q;
    assign nLED_STANDBY  = nstby_q;
    assign nLED_DELAYING = ndly_q;
    assign STATE         = state_q;

endmodule

// File: tb/tb_bubbledrive8_supervisor.sv
// Scoreboard bench for bubbledrive8_supervisor. A reference model, written in terms of
// elapsed cycles per state, pushes the expected outputs after every clock edge; a
// monitor pops and compares on the falling edge.
module tb_bubbledrive8_supervisor;

    localparam int B = 4;
    localparam int S = 2;
    localparam int D = 3;
    localparam int W = 10;

    logic         MCLK = 1'b0;
    logic         RST, PWRSTAT, MRST, nDELAYING_IN;
    logic [W-1:0] SWIN;
    logic [W-1:0] SETTINGS;
    logic         nEMUEN, nTEMPEN, nFIFOEN, nMPSSEEN;
    logic         nLED_PWROK, nLED_STANDBY, nLED_DELAYING;
    logic [2:0]   STATE;

    bubbledrive8_supervisor #(
        .BLINK_CYCLES(B), .SETTLE_TICKS(S), .DEBOUNCE_CYCLES(D), .SW_WIDTH(W)
    ) dut (
        .MCLK(MCLK), .RST(RST), .PWRSTAT(PWRSTAT), .MRST(MRST), .SWIN(SWIN),
        .nDELAYING_IN(nDELAYING_IN), .SETTINGS(SETTINGS), .nEMUEN(nEMUEN),
        .nTEMPEN(nTEMPEN), .nFIFOEN(nFIFOEN), .nMPSSEEN(nMPSSEEN),
        .nLED_PWROK(nLED_PWROK), .nLED_STANDBY(nLED_STANDBY),
        .nLED_DELAYING(nLED_DELAYING), .STATE(STATE)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        logic [2:0]   state;
        logic [W-1:0] settings;
        logic         nemu, ntemp, nfifo, nmpsse, npwr, nstby, ndly;
    } obs_t;

    obs_t sb[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model state
    int         m_state = 0;
    logic [W-1:0] m_settings = '0;
    logic [1:0] m_stable = 2'b11;
    int         m_mis = 0;      // consecutive debounced samples differing from stable
    int         m_age = 0;      // clock edges spent in the current blink-enabled state
    logic [1:0] m_raw1 = 2'b11; // raw pins one edge ago
    logic [1:0] m_raw2 = 2'b11; // raw pins two edges ago

    function automatic bit m_blink(input int age);
        return ((age / B) % 2) == 0;
    endfunction

    // Reference model: one evaluation per rising edge, expected outputs queued.
    initial begin : model
        forever begin
            obs_t e;
            int   st, nxt, tc;
            bit   bo, en;
            @(posedge MCLK);
            st = m_state;
            bo = m_blink(m_age);
            tc = (m_age / B > S) ? S : m_age / B;
            en = (st == 1 || st == 4 || st == 5 || st == 6);
            case (st)
                0: nxt = 1;
                1: nxt = (tc == S) ? 2 : 1;
                2: nxt = (m_stable == 2'b00) ? 3 : (m_stable == 2'b01) ? 5 :
                         (m_stable == 2'b10) ? 6 : 4;
                3: nxt = (m_stable == 2'b00) ? 3 : 0;
                4: nxt = (m_stable == 2'b11) ? 4 : 0;
                5: nxt = m_stable[0] ? 5 : 0;
                6: nxt = (m_stable == 2'b10) ? 6 : 0;
                default: nxt = 0;
            endcase
            if (RST) begin
                e = '1;
                e.state = 3'd0;
                e.settings = '0;
                m_settings = '0;
                m_state = 0;
                m_age = 0;
                m_stable = 2'b11;
                m_mis = 0;
            end else begin
                if (st == 0) m_settings = ~SWIN;
                e.state    = 3'(nxt);
                e.settings = m_settings;
                e.nemu     = (st != 3);
                e.ntemp    = (st != 3);
                e.nfifo    = (st != 3);
                e.nmpsse   = (st != 4);
                e.npwr     = (st == 3 || st == 4) ? 1'b0 :
                             (st == 1 || st == 5 || st == 6) ? bo : 1'b1;
                e.nstby    = !((st == 4 && !bo) || !nDELAYING_IN);
                e.ndly     = !(st == 3 && !nDELAYING_IN);
                if (m_raw2 == m_stable) m_mis = 0;
                else if (m_mis + 1 == D) begin m_stable = m_raw2; m_mis = 0; end
                else m_mis++;
                m_age   = en ? m_age + 1 : 0;
                m_state = nxt;
            end
            m_raw2 = m_raw1;
            m_raw1 = {PWRSTAT, MRST};
            sb.push_back(e);
        end
    end

    // Monitor: compare the DUT against the oldest queued expectation away from the edge.
    initial begin : monitor
        forever begin
            obs_t a, e;
            @(negedge MCLK);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                a = {STATE, SETTINGS, nEMUEN, nTEMPEN, nFIFOEN, nMPSSEEN,
                     nLED_PWROK, nLED_STANDBY, nLED_DELAYING};
                total++;
                if (a === e) passed++;
                else $display("FAIL scoreboard t=%0t: got st=%0d set=%h en=%b%b%b%b led=%b%b%b, expected st=%0d set=%h en=%b%b%b%b led=%b%b%b",
                    $time, a.state, a.settings, a.nemu, a.ntemp, a.nfifo, a.nmpsse,
                    a.npwr, a.nstby, a.ndly, e.state, e.settings, e.nemu, e.ntemp,
                    e.nfifo, e.nmpsse, e.npwr, e.nstby, e.ndly);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge MCLK);
        #2;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic wait_state(input int s, input int bound, input string nm);
        int n = 0;
        while (int'(STATE) != s && n < bound) begin
            cyc(1);
            n++;
        end
        check(nm, int'(STATE), s);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int w;
        RST = 1'b1; PWRSTAT = 1'b0; MRST = 1'b0; SWIN = 10'h3F0; nDELAYING_IN = 1'b1;
        cyc(3);
        check("reset_state", int'(STATE), 0);
        check("reset_settings", int'(SETTINGS), 0);
        check("reset_nemuen", int'(nEMUEN), 1);

        // Bring-up into EMULATOR
        RST = 1'b0;
        cyc(1);
        check("settle_entry", int'(STATE), 1);
        check("settings_latched", int'(SETTINGS), 'h00F);
        SWIN = 10'h2AA;
        wait_state(3, 30, "reach_emulator");
        cyc(2);
        check("emu_enable", int'(nEMUEN), 0);
        check("emu_mpsse_off", int'(nMPSSEEN), 1);
        check("settings_hold", int'(SETTINGS), 'h00F);

        // Short MRST glitch is filtered
        MRST = 1'b1; cyc(2); MRST = 1'b0;
        cyc(10);
        check("glitch_ignored", int'(STATE), 3);

        // Sustained MRST loss -> RESET, then ERR_BOARD
        MRST = 1'b1;
        wait_state(0, 15, "mrst_to_reset");
        wait_state(5, 30, "reach_err_board");
        cyc(12);
        MRST = 1'b0;
        wait_state(0, 15, "err_board_exit");
        wait_state(3, 30, "back_to_emulator");

        // Delaying flag in EMULATOR
        cyc(2);
        nDELAYING_IN = 1'b0; cyc(2);
        check("delay_led_on", int'(nLED_DELAYING), 0);
        check("standby_led_delay", int'(nLED_STANDBY), 0);
        nDELAYING_IN = 1'b1; cyc(2);
        check("delay_led_off", int'(nLED_DELAYING), 1);

        // USB power -> MPSSE_STANDBY
        PWRSTAT = 1'b1; MRST = 1'b1;
        wait_state(4, 40, "reach_standby");
        cyc(10);
        check("standby_mpsse", int'(nMPSSEEN), 0);
        check("standby_pwrok", int'(nLED_PWROK), 0);

        // Reset while blink is low in standby
        w = 0;
        while (!(m_state == 4 && !m_blink(m_age)) && w < 20) begin cyc(1); w++; end
        check("standby_blink_low", (m_state == 4 && !m_blink(m_age)) ? 1 : 0, 1);
        RST = 1'b1; cyc(1);
        check("rst_state", int'(STATE), 0);
        check("rst_mpsse", int'(nMPSSEEN), 1);
        check("rst_leds", int'({nLED_PWROK, nLED_STANDBY, nLED_DELAYING}), 7);
        check("rst_settings", int'(SETTINGS), 0);
        cyc(2);
        RST = 1'b0;

        // Randomised pin activity, switch noise and occasional resets
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 2);
                1:       len = $urandom_range(3, 8);
                default: len = $urandom_range(15, 40);
            endcase
            {PWRSTAT, MRST} = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) nDELAYING_IN = ~nDELAYING_IN;
            for (int i = 0; i < len; i++) begin
                SWIN = 10'($urandom);
                RST  = ($urandom_range(0, 199) == 0);
                cyc(1);
            end
        end
        RST = 1'b0;
        cyc(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
